// File: rtl/beep_pkg.sv
// Shared types for the beep scheduler: FSM encoding, requester indices and the
// fixed per-requester beep pattern table.
package beep_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } state_e;

    localparam int NUM_REQ    = 3;
    localparam int REQ_KEY    = 0;
    localparam int REQ_DOUBLE = 1;
    localparam int REQ_LONG   = 2;

    typedef struct packed {
        logic [1:0] beeps;
        logic       is_long;
    } pattern_t;

    function automatic pattern_t pattern_of(input logic [NUM_REQ-1:0] sel);
        pattern_t p;
        p.beeps   = 2'd1;
        p.is_long = 1'b0;
        if (sel[REQ_LONG]) begin
            p.beeps   = 2'd1;
            p.is_long = 1'b1;
        end else if (sel[REQ_DOUBLE]) begin
            p.beeps   = 2'd2;
            p.is_long = 1'b0;
        end
        return p;
    endfunction

    // One-hot of the highest set bit; the later loop iterations win.
    function automatic logic [NUM_REQ-1:0] pick_highest(input logic [NUM_REQ-1:0] pend);
        logic [NUM_REQ-1:0] g;
        g = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pend[i]) begin
                g    = '0;
                g[i] = 1'b1;
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/beep_scheduler_if.sv
// Request/grant and buzzer signals of the beep scheduler, plus a debug view of its FSM.
interface beep_scheduler_if;
    import beep_pkg::*;

    // req bits are one-cycle pulses that are remembered until served; grant is a
    // one-hot one-cycle pulse naming the requester whose pattern starts next.
    logic [NUM_REQ-1:0] req;
    logic               mute;
    logic               abort;
    logic [NUM_REQ-1:0] grant;
    logic               busy;
    logic               beep;
    state_e             dbg_state;

    modport master (output req, mute, abort, input grant, busy, beep, dbg_state);
    modport slave  (input req, mute, abort, output grant, busy, beep, dbg_state);

endinterface

// File: rtl/beep_tone_gen.sv
// Square-wave (or constant) buzzer drive; the waveform restarts high whenever run rises.
module beep_tone_gen #(
    parameter int TONE_HALF = 50_000,
    parameter int TONE_EN   = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic mute,
    output logic beep
);

    localparam int CW = $clog2(TONE_HALF + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          lvl_q, lvl_d;
    logic          run_q;
    logic          beep_q, beep_d;

    always_comb begin
        cnt_d = '0;
        lvl_d = 1'b1;
        if (run && run_q) begin
            if (cnt_q == CW'(TONE_HALF - 1)) begin
                cnt_d = '0;
                lvl_d = ~lvl_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
                lvl_d = lvl_q;
            end
        end
        beep_d = run && !mute && ((TONE_EN != 0) ? lvl_d : 1'b1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            lvl_q  <= 1'b0;
            run_q  <= 1'b0;
            beep_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            lvl_q  <= lvl_d;
            run_q  <= run;
            beep_q <= beep_d;
        end
    end

    assign beep = beep_q;

endmodule

// File: rtl/beep_scheduler.sv
// Priority beep scheduler: latches request pulses and plays one fixed beep pattern
// at a time, non-preemptive, with exact ON/OFF timing counted from each state entry.
module beep_scheduler
    import beep_pkg::*;
#(
    parameter int UNIT_CNT  = 200_000,
    parameter int TONE_HALF = 50_000,
    parameter int TONE_EN   = 1,
    parameter int SHORT_MS  = 100,
    parameter int LONG_MS   = 500,
    parameter int GAP_MS    = 100
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    beep_scheduler_if.slave   bus
);

    localparam int MAX_ON = (LONG_MS > SHORT_MS) ? LONG_MS : SHORT_MS;
    localparam int MAX_MS = (GAP_MS > MAX_ON) ? GAP_MS : MAX_ON;
    localparam int UW     = $clog2(UNIT_CNT + 1);
    localparam int MW     = $clog2(MAX_MS + 1);

    state_e             state_q, state_d;
    logic [NUM_REQ-1:0] pending_q, pending_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic               busy_q, busy_d;
    logic [1:0]         beeps_q, beeps_d;
    logic               long_q, long_d;
    logic [UW-1:0]      unit_q, unit_d;
    logic [MW-1:0]      ms_q, ms_d;

    logic [NUM_REQ-1:0] pick;
    logic [NUM_REQ-1:0] served;
    pattern_t           pat;
    logic               unit_last;
    logic               take;
    logic [MW-1:0]      on_last;

    always_comb begin
        state_d   = state_q;
        beeps_d   = beeps_q;
        long_d    = long_q;
        grant_d   = '0;
        served    = '0;
        take      = 1'b0;
        pick      = pick_highest(pending_q);
        pat       = pattern_of(pick);
        unit_last = (unit_q == UW'(UNIT_CNT - 1));
        on_last   = long_q ? MW'(LONG_MS - 1) : MW'(SHORT_MS - 1);
        unit_d    = unit_last ? '0 : unit_q + UW'(1);
        ms_d      = unit_last ? ms_q + MW'(1) : ms_q;

        case (state_q)
            ST_IDLE: begin
                unit_d = '0;
                ms_d   = '0;
                // The grant pulse occupies one IDLE cycle; ON follows it.
                if (grant_q != '0) begin
                    state_d = ST_ON;
                end else begin
                    take = (pending_q != '0);
                end
            end
            ST_ON: begin
                if (unit_last && ms_q == on_last) begin
                    state_d = ST_OFF;
                    unit_d  = '0;
                    ms_d    = '0;
                    beeps_d = beeps_q - 2'd1;
                end
            end
            ST_OFF: begin
                if (unit_last && ms_q == MW'(GAP_MS - 1)) begin
                    unit_d = '0;
                    ms_d   = '0;
                    if (beeps_q != '0) begin
                        state_d = ST_ON;
                    end else begin
                        state_d = ST_IDLE;
                        take    = (pending_q != '0);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                unit_d  = '0;
                ms_d    = '0;
            end
        endcase

        if (take) begin
            served  = pick;
            grant_d = pick;
            beeps_d = pat.beeps;
            long_d  = pat.is_long;
        end

        // A req pulse landing on its own service cycle stays pending.
        pending_d = (pending_q & ~served) | bus.req;

        if (bus.abort) begin
            state_d   = ST_IDLE;
            pending_d = '0;
            grant_d   = '0;
            beeps_d   = '0;
            unit_d    = '0;
            ms_d      = '0;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q   <= ST_IDLE;
            pending_q <= '0;
            grant_q   <= '0;
            busy_q    <= 1'b0;
            beeps_q   <= '0;
            long_q    <= 1'b0;
            unit_q    <= '0;
            ms_q      <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            grant_q   <= grant_d;
            busy_q    <= busy_d;
            beeps_q   <= beeps_d;
            long_q    <= long_d;
            unit_q    <= unit_d;
            ms_q      <= ms_d;
        end
    end

    beep_tone_gen #(
        .TONE_HALF (TONE_HALF),
        .TONE_EN   (TONE_EN)
    ) u_tone (
        .clk  (sys_clk),
        .rst  (sys_rst),
        .run  (state_d == ST_ON),
        .mute (bus.mute),
        .beep (bus.beep)
    );

    assign bus.grant     = grant_q;
    assign bus.busy      = busy_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_beep_scheduler.sv
// Directed bench for beep_scheduler with a small time base (UNIT_CNT=4, TONE_HALF=2,
// SHORT_MS=2, LONG_MS=5, GAP_MS=1); every cycle is compared as {grant,busy,beep,state}.
module tb_beep_scheduler;
    import beep_pkg::*;

    logic clk;
    logic sys_rst;
    int   checks;
    int   passes;

    logic [6:0] exp_q[$];

    beep_scheduler_if bus();

    beep_scheduler #(
        .UNIT_CNT  (4),
        .TONE_HALF (2),
        .TONE_EN   (1),
        .SHORT_MS  (2),
        .LONG_MS   (5),
        .GAP_MS    (1)
    ) dut (
        .sys_clk (clk),
        .sys_rst (sys_rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] sample();
        return {bus.grant, bus.busy, bus.beep, 2'(bus.dbg_state)};
    endfunction

    // Expected-cycle builders; the tone with TONE_HALF=2 is 1,1,0,0 repeating from ON entry.
    task automatic exp_idle(input logic [2:0] g);
        exp_q.push_back({g, 1'b0, 1'b0, 2'(ST_IDLE)});
    endtask

    task automatic exp_on(input int n, input logic muted);
        for (int k = 0; k < n; k++)
            exp_q.push_back({3'b000, 1'b1, (!muted && (k % 4) < 2), 2'(ST_ON)});
    endtask

    task automatic exp_off(input int n);
        for (int k = 0; k < n; k++)
            exp_q.push_back({3'b000, 1'b1, 1'b0, 2'(ST_OFF)});
    endtask

    task automatic test_reset();
        logic [6:0] exp;
        logic [6:0] obs;
        int c = 0;
        sys_rst   = 1'b1;
        bus.req   = 3'b111;
        bus.mute  = 1'b0;
        bus.abort = 1'b0;
        tick();
        for (int i = 0; i < 6; i++) exp_idle(3'b000);
        while (exp_q.size() != 0) begin
            exp = exp_q.pop_front();
            obs = sample();
            checks++;
            if (obs !== exp)
                $display("FAIL reset[%0d]: got {grant,busy,beep,state}=%b, expected %b", c, obs, exp);
            else
                passes++;
            if (c == 1) begin
                sys_rst = 1'b0;
                bus.req = '0;
            end
            tick();
            c++;
        end
    endtask

    task automatic test_single();
        logic [6:0] exp;
        logic [6:0] obs;
        int c = 0;
        int busy_cycles = 0;
        bus.req = 3'b001;
        tick();
        bus.req = '0;
        exp_idle(3'b000);
        exp_idle(3'b001);
        exp_on(8, 1'b0);
        exp_off(4);
        exp_idle(3'b000);
        while (exp_q.size() != 0) begin
            exp = exp_q.pop_front();
            obs = sample();
            if (bus.busy === 1'b1) busy_cycles++;
            checks++;
            if (obs !== exp)
                $display("FAIL single[%0d]: got {grant,busy,beep,state}=%b, expected %b", c, obs, exp);
            else
                passes++;
            tick();
            c++;
        end
        checks++;
        if (busy_cycles !== 12)
            $display("FAIL single_busy_len: got %0d busy cycles, expected 12", busy_cycles);
        else
            passes++;
    endtask

    task automatic test_double_then_key();
        logic [6:0] exp;
        logic [6:0] obs;
        int c = 0;
        bus.req = 3'b011;
        tick();
        bus.req = '0;
        exp_idle(3'b000);
        exp_idle(3'b010);
        exp_on(8, 1'b0);
        exp_off(4);
        exp_on(8, 1'b0);
        exp_off(4);
        exp_idle(3'b001);
        exp_on(8, 1'b0);
        exp_off(4);
        exp_idle(3'b000);
        while (exp_q.size() != 0) begin
            exp = exp_q.pop_front();
            obs = sample();
            checks++;
            if (obs !== exp)
                $display("FAIL double[%0d]: got {grant,busy,beep,state}=%b, expected %b", c, obs, exp);
            else
                passes++;
            tick();
            c++;
        end
    endtask

    task automatic test_no_preempt();
        logic [6:0] exp;
        logic [6:0] obs;
        int c = 0;
        bus.req = 3'b001;
        tick();
        bus.req = '0;
        exp_idle(3'b000);
        exp_idle(3'b001);
        exp_on(8, 1'b0);
        exp_off(4);
        exp_idle(3'b100);
        exp_on(20, 1'b0);
        exp_off(4);
        exp_idle(3'b001);
        exp_on(8, 1'b0);
        exp_off(4);
        exp_idle(3'b000);
        while (exp_q.size() != 0) begin
            exp = exp_q.pop_front();
            obs = sample();
            checks++;
            if (obs !== exp)
                $display("FAIL no_preempt[%0d]: got {grant,busy,beep,state}=%b, expected %b", c, obs, exp);
            else
                passes++;
            bus.req = '0;
            if (c == 4) bus.req = 3'b100;
            if (c == 6) bus.req = 3'b001;
            tick();
            c++;
        end
        bus.req = '0;
    endtask

    task automatic test_mute();
        logic [6:0] exp;
        logic [6:0] obs;
        int c = 0;
        bus.mute = 1'b1;
        bus.req  = 3'b010;
        tick();
        bus.req = '0;
        exp_idle(3'b000);
        exp_idle(3'b010);
        exp_on(8, 1'b1);
        exp_off(4);
        exp_on(8, 1'b1);
        exp_off(4);
        exp_idle(3'b000);
        while (exp_q.size() != 0) begin
            exp = exp_q.pop_front();
            obs = sample();
            checks++;
            if (obs !== exp)
                $display("FAIL mute[%0d]: got {grant,busy,beep,state}=%b, expected %b", c, obs, exp);
            else
                passes++;
            tick();
            c++;
        end
        bus.mute = 1'b0;
    endtask

    task automatic test_abort();
        logic [6:0] exp;
        logic [6:0] obs;
        int c = 0;
        bus.req = 3'b001;
        tick();
        bus.req = '0;
        exp_idle(3'b000);
        exp_idle(3'b001);
        exp_on(3, 1'b0);
        for (int i = 0; i < 8; i++) exp_idle(3'b000);
        while (exp_q.size() != 0) begin
            exp = exp_q.pop_front();
            obs = sample();
            checks++;
            if (obs !== exp)
                $display("FAIL abort[%0d]: got {grant,busy,beep,state}=%b, expected %b", c, obs, exp);
            else
                passes++;
            bus.req   = '0;
            bus.abort = 1'b0;
            if (c == 2) bus.req = 3'b100;
            if (c == 4) begin
                bus.abort = 1'b1;
                bus.req   = 3'b001;
            end
            tick();
            c++;
        end
        bus.req   = '0;
        bus.abort = 1'b0;
    endtask

    task automatic test_reset_mid_off();
        logic [6:0] exp;
        logic [6:0] obs;
        int c = 0;
        bus.req = 3'b010;
        tick();
        bus.req = '0;
        exp_idle(3'b000);
        exp_idle(3'b010);
        exp_on(8, 1'b0);
        exp_off(2);
        for (int i = 0; i < 9; i++) exp_idle(3'b000);
        while (exp_q.size() != 0) begin
            exp = exp_q.pop_front();
            obs = sample();
            checks++;
            if (obs !== exp)
                $display("FAIL reset_mid[%0d]: got {grant,busy,beep,state}=%b, expected %b", c, obs, exp);
            else
                passes++;
            if (c == 11) begin
                sys_rst = 1'b1;
                bus.req = 3'b100;
            end else if (c == 12) begin
                sys_rst = 1'b0;
                bus.req = '0;
            end
            tick();
            c++;
        end
    endtask

    initial begin
        checks    = 0;
        passes    = 0;
        sys_rst   = 1'b1;
        bus.req   = '0;
        bus.mute  = 1'b0;
        bus.abort = 1'b0;
        test_reset();
        test_single();
        test_double_then_key();
        test_no_preempt();
        test_mute();
        test_abort();
        test_reset_mid_off();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/beep_scheduler.md
BEEP_SCHEDULER -- requirements
Module: beep_scheduler

Interface
REQ-001 SHALL have parameter UNIT_CNT, default 200_000, clocks per 1 ms time unit (200 MHz sys_clk).
REQ-002 SHALL have parameter TONE_HALF, default 50_000, clocks per half-period of the tone (2 kHz).
REQ-003 SHALL have parameter TONE_EN, default 1: 1 = square-wave tone while sounding, 0 = constant high (active buzzer).
REQ-004 SHALL have parameter SHORT_MS, default 100, short-beep on-time in units.
REQ-005 SHALL have parameter LONG_MS, default 500, long-beep on-time in units.
REQ-006 SHALL have parameter GAP_MS, default 100, off-time after every beep in units.
REQ-007 SHALL have one clock and a synchronous, active-high reset: sys_clk input 1, the single clock; sys_rst input 1, the synchronous active-high reset.
REQ-008 SHALL have req input 3, per-requester one-cycle request pulses (req[0] = debounced key event; bit 2 is highest priority).
REQ-009 SHALL have mute input 1, a level that forces beep low without altering sequencing.
REQ-010 SHALL have abort input 1, a pulse that cancels the current pattern and all pending requests.
REQ-011 SHALL have grant output 3, a one-hot one-cycle pulse marking the requester whose pattern starts.
REQ-012 SHALL have busy output 1, high while a pattern plays.
REQ-013 SHALL have beep output 1, the buzzer drive, active-high.

Function
REQ-014 SHALL latch each req bit into pending[i]; pending_next = (pending & ~served) | req, so a request coincident with its own service remains pending.
REQ-015 SHALL hold at most one pending request per requester; repeated pulses while pending merge.
REQ-016 SHALL use FSM states IDLE, ON and OFF.
REQ-017 In IDLE with any pending bit set, SHALL select the highest set index, pulse grant for that cycle, clear its pending bit and enter ON on the next cycle.
REQ-018 SHALL use fixed patterns: requester 0 = 1 beep of SHORT_MS; requester 1 = 2 beeps of SHORT_MS; requester 2 = 1 beep of LONG_MS.
REQ-019 SHALL hold ON for exactly on_ms*UNIT_CNT cycles, then OFF for exactly GAP_MS*UNIT_CNT cycles.
REQ-020 At the end of OFF, SHALL return to ON if beeps remain, otherwise go to IDLE; a new grant is possible in the first IDLE cycle.
REQ-021 SHALL restart the unit and ms counters to 0 on every state entry; there is no free-running tick, so timing is exact.
REQ-022 SHALL not preempt: a higher-priority request arriving mid-pattern waits for IDLE.
REQ-023 SHALL set busy = (state != IDLE), registered.
REQ-024 With TONE_EN=1, beep in ON SHALL start high on the first ON cycle and toggle every TONE_HALF cycles; with TONE_EN=0, beep SHALL be 1 throughout ON.
REQ-025 beep SHALL be 0 in IDLE and OFF, and whenever mute=1.
REQ-026 All outputs SHALL be registered; beep is asserted in the same cycle state becomes ON.
REQ-027 abort SHALL force IDLE, clear pending, drive beep low and suppress grant on the next cycle; a req in the abort cycle is discarded.
REQ-028 Counter widths SHALL be sized with $clog2 of the parameter maxima; no wrap-around is permitted within a state.

Reset
REQ-029 When sys_rst=1 at a clock edge, the block SHALL set state=IDLE, pending=0, all counters=0, grant=0, busy=0 and beep=0.
REQ-030 Reset SHALL take effect mid-pattern identically to REQ-029, and req pulses during reset SHALL be ignored.

Structure
REQ-031 Package beep_pkg SHALL hold the state encoding, the requester index constants and the per-requester pattern table (beep count, on-time select).
REQ-032 Tone generation SHALL live in the sub-module beep_tone_gen (inputs: run and mute; output: beep), restarted on each ON entry.

Verification (UNIT_CNT=4, TONE_HALF=2, SHORT_MS=2, LONG_MS=5, GAP_MS=1)
REQ-033 Pulse req[0] in IDLE -> grant=001 in the next cycle; ON for 8 cycles with beep pattern 1,1,0,0,1,1,0,0; OFF 4 cycles; busy is high for 12 cycles.
REQ-034 Pulse req=011 in one cycle -> grant=010 first, with two beeps of 8 cycles separated by 4 OFF cycles; grant=001 in the first IDLE cycle after.
REQ-035 During requester 0's pattern, pulse req[2] then req[0] -> no preemption; after IDLE, grant=100 (20-cycle ON), then grant=001.
REQ-036 Hold mute=1 through a req[1] pattern -> beep stays 0; busy and grant timing are identical to the unmuted case.
REQ-037 Pulse abort in the 3rd ON cycle with req[2] pending -> next cycle IDLE, beep=0, busy=0, pending=0, and no grant follows.
REQ-038 Assert sys_rst mid-OFF together with a req pulse -> all outputs are 0 the next cycle, and no grant occurs after reset releases.
